regfile_port_arbiter: RTL and testbench



---
 rtl/regfile_arb_pkg.sv | 24 ++
 rtl/regfile_bank.sv | 51 +++++
 rtl/regfile_port_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the two-requester register-bank arbiter.
// Optional feature macro: REGFILE_ARB_WRITE_PRIO_EN (see regfile_port_arbiter).
package regfile_arb_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    localparam int NUM_REGS_DEF = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 4;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } req_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] num_regs);
        return (addr < num_regs);
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// Single-port register storage: synchronous write, registered read, range check,
// synchronous clear on rst.
module regfile_bank
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    logic [DATA_W-1:0] mem_r [NUM_REGS];
    logic [DATA_W-1:0] rdata_r;
    logic              err_r;
    logic              in_range_s;

    assign in_range_s = addr_in_range(32'(addr), 32'(NUM_REGS));
    assign rdata      = rdata_r;
    assign err        = err_r;

    // Storage update, registered read word and one-cycle range-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else if (en) begin
            err_r <= !in_range_s;
            if (we) begin
                if (in_range_s) begin
                    mem_r[addr] <= wdata;
                end
            end else begin
                rdata_r <= in_range_s ? mem_r[addr] : {DATA_W{1'b0}};
            end
        end else begin
            err_r <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one regfile_bank between requesters A and B.
// Define REGFILE_ARB_WRITE_PRIO_EN to favour the writer when A and B collide.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              stall
);

    req_id_e           prio_r;
    req_id_e           owner_r;
    logic              gnt_a_s;
    logic              gnt_b_s;
    req_t              sel_s;
    logic              a_rvalid_r;
    logic              b_rvalid_r;
    logic [DATA_W-1:0] a_hold_r;
    logic [DATA_W-1:0] b_hold_r;
    logic [DATA_W-1:0] bank_rdata_s;
    logic              bank_err_s;

    // Grant decision; nothing is granted while rst is high.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (rst) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else if (a_valid && b_valid) begin
`ifdef REGFILE_ARB_WRITE_PRIO_EN
            if (a_we != b_we) begin
                gnt_a_s = a_we;
                gnt_b_s = b_we;
            end else begin
                gnt_a_s = (prio_r == REQ_A);
                gnt_b_s = (prio_r == REQ_B);
            end
`else
            gnt_a_s = (prio_r == REQ_A);
            gnt_b_s = (prio_r == REQ_B);
`endif
        end else begin
            gnt_a_s = a_valid;
            gnt_b_s = b_valid;
        end
    end

    // Steer the granted requester's access onto the bank port.
    always_comb begin
        sel_s = '0;
        if (gnt_b_s) begin
            sel_s.we    = b_we;
            sel_s.addr  = ADDR_W_DEF'(b_addr);
            sel_s.wdata = DATA_W_DEF'(b_wdata);
        end else begin
            sel_s.we    = a_we;
            sel_s.addr  = ADDR_W_DEF'(a_addr);
            sel_s.wdata = DATA_W_DEF'(a_wdata);
        end
    end

    regfile_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .en    (gnt_a_s || gnt_b_s),
        .we    (sel_s.we),
        .addr  (ADDR_W'(sel_s.addr)),
        .wdata (DATA_W'(sel_s.wdata)),
        .rdata (bank_rdata_s),
        .err   (bank_err_s)
    );

    // Priority rotation, read-valid pulses, last owner and per-requester held data.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r     <= REQ_A;
            owner_r    <= REQ_A;
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
            a_hold_r   <= {DATA_W{1'b0}};
            b_hold_r   <= {DATA_W{1'b0}};
        end else begin
            if (gnt_a_s) begin
                prio_r <= REQ_B;
            end else if (gnt_b_s) begin
                prio_r <= REQ_A;
            end else begin
                prio_r <= prio_r;
            end
            owner_r    <= gnt_b_s ? REQ_B : REQ_A;
            a_rvalid_r <= gnt_a_s && !a_we;
            b_rvalid_r <= gnt_b_s && !b_we;
            a_hold_r   <= a_rvalid_r ? bank_rdata_s : a_hold_r;
            b_hold_r   <= b_rvalid_r ? bank_rdata_s : b_hold_r;
        end
    end

    // Pulses due while rst is high are cancelled rather than delivered.
    assign a_ready  = gnt_a_s;
    assign b_ready  = gnt_b_s;
    assign a_rvalid = a_rvalid_r && !rst;
    assign b_rvalid = b_rvalid_r && !rst;
    assign a_err    = bank_err_s && (owner_r == REQ_A) && !rst;
    assign b_err    = bank_err_s && (owner_r == REQ_B) && !rst;
    assign a_rdata  = a_rvalid ? bank_rdata_s : a_hold_r;
    assign b_rdata  = b_rvalid ? bank_rdata_s : b_hold_r;
    assign stall    = !rst && ((a_valid && !gnt_a_s) || (b_valid && !gnt_b_s));

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_we, b_valid, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err, stall;
    logic [31:0] a_rdata, b_rdata;

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .stall(stall)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: index 0 = A, 1 = B
    int          m_prio;
    logic [31:0] m_mem [10];
    bit          m_rv [2];
    bit          m_err [2];
    logic [31:0] m_data [2];
    logic [31:0] m_hold [2];
    bit          m_g [2];

    // One cycle: drive inputs after the falling edge, check all outputs, advance the model.
    task automatic step(input bit r,
                        input bit av, input bit awe, input logic [3:0] aa, input logic [31:0] ad,
                        input bit bv, input bit bwe, input logic [3:0] ba, input logic [31:0] bd);
        bit v[2], we[2], sh_rv[2], exp_stall;
        logic [3:0]  ad_[2];
        logic [31:0] wd[2], sh_data[2];
        logic [31:0] o_rdy[2], o_rv[2], o_err[2], o_dat[2];
        int win;
        @(negedge clk);
        rst = r;
        a_valid = av; a_we = awe; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_we = bwe; b_addr = ba; b_wdata = bd;
        #1;
        v[0] = av; we[0] = awe; ad_[0] = aa; wd[0] = ad;
        v[1] = bv; we[1] = bwe; ad_[1] = ba; wd[1] = bd;
        m_g[0] = 1'b0; m_g[1] = 1'b0;
        if (!r) begin
            if (v[0] && v[1]) begin
                win = m_prio;
`ifdef REGFILE_ARB_WRITE_PRIO_EN
                if (we[0] != we[1]) win = we[0] ? 0 : 1;
`endif
                m_g[win] = 1'b1;
            end else begin
                m_g[0] = v[0];
                m_g[1] = v[1];
            end
        end
        exp_stall = !r && ((v[0] && !m_g[0]) || (v[1] && !m_g[1]));
        o_rdy[0] = a_ready;  o_rv[0] = a_rvalid; o_err[0] = a_err; o_dat[0] = a_rdata;
        o_rdy[1] = b_ready;  o_rv[1] = b_rvalid; o_err[1] = b_err; o_dat[1] = b_rdata;
        check("stall", stall, exp_stall);
        for (int i = 0; i < 2; i++) begin
            sh_rv[i]   = m_rv[i] && !r;
            sh_data[i] = sh_rv[i] ? m_data[i] : m_hold[i];
            check(i == 0 ? "a_ready"  : "b_ready",  o_rdy[i], 32'(m_g[i]));
            check(i == 0 ? "a_rvalid" : "b_rvalid", o_rv[i],  32'(sh_rv[i]));
            check(i == 0 ? "a_err"    : "b_err",    o_err[i], 32'(m_err[i] && !r));
            check(i == 0 ? "a_rdata"  : "b_rdata",  o_dat[i], sh_data[i]);
        end
        if (r) begin
            m_prio = 0;
            for (int k = 0; k < 10; k++) m_mem[k] = 32'd0;
            for (int i = 0; i < 2; i++) begin
                m_rv[i] = 1'b0; m_err[i] = 1'b0; m_data[i] = 32'd0; m_hold[i] = 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_hold[i] = sh_data[i];
                m_rv[i]   = 1'b0;
                m_err[i]  = 1'b0;
                if (m_g[i]) begin
                    m_err[i] = (ad_[i] >= 4'd10);
                    m_prio   = 1 - i;
                    if (we[i]) begin
                        if (ad_[i] < 4'd10) m_mem[ad_[i]] = wd[i];
                    end else begin
                        m_rv[i]   = 1'b1;
                        m_data[i] = (ad_[i] < 4'd10) ? m_mem[ad_[i]] : 32'd0;
                    end
                end
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    bit          p_v [2];
    bit          p_we [2];
    logic [3:0]  p_ad [2];
    logic [31:0] p_wd [2];
    bit          r_rand;

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_addr = 4'd0; a_wdata = 32'd0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_wdata = 32'd0;
        m_prio = 0;
        for (int k = 0; k < 10; k++) m_mem[k] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 1'b0; m_err[i] = 1'b0; m_data[i] = 32'd0; m_hold[i] = 32'd0;
            p_v[i] = 1'b0; p_we[i] = 1'b0; p_ad[i] = 4'd0; p_wd[i] = 32'd0;
        end

        // Reset, idle, read of reg 3 returns 0
        do_reset();
        idle();
        check("idle_stall", stall, 32'd0);
        step(1'b0, 1'b1, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        idle();
        check("rd3_rvalid", a_rvalid, 32'd1);
        check("rd3_rdata", a_rdata, 32'd0);

        // A writes reg 5, B reads it next cycle
        step(1'b0, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd5, 32'd0);
        check("raw_b_ready", b_ready, 32'd1);
        idle();
        check("raw_b_rvalid", b_rvalid, 32'd1);
        check("raw_b_rdata", b_rdata, 32'hDEADBEEF);

        // Both reading for 4 cycles right after reset: A, B, A, B
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'd1, 32'd0, 1'b1, 1'b0, 4'd2, 32'd0);
            check("rr_a_ready", a_ready, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_stall", stall, 32'd1);
        end
        idle();

        // Out-of-range read and dropped out-of-range write
        step(1'b0, 1'b1, 1'b0, 4'd12, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 4'd10, 32'h1, 1'b0, 1'b0, 4'd0, 32'd0);
        check("oor_rd_err", a_err, 32'd1);
        check("oor_rd_data", a_rdata, 32'd0);
        idle();
        check("oor_wr_err", a_err, 32'd1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'(k), 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        end
        idle();

        // Contention: A read vs B write with prio = A
        do_reset();
        step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 4'd1, 32'h55);
`ifdef REGFILE_ARB_WRITE_PRIO_EN
        check("cont_first_b", b_ready, 32'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        check("cont_then_a", a_ready, 32'd1);
`else
        check("cont_first_a", a_ready, 32'd1);
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 4'd1, 32'h55);
        check("cont_then_b", b_ready, 32'd1);
`endif
        idle();

        // Reset mid-operation cancels the pending read pulse and clears the bank
        step(1'b0, 1'b1, 1'b0, 4'd1, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        check("rst_cancel_rvalid", a_rvalid, 32'd0);
        step(1'b0, 1'b1, 1'b0, 4'd1, 32'd0, 1'b1, 1'b0, 4'd1, 32'd0);
        check("rst_prio_a", a_ready, 32'd1);
        idle();
        check("rst_cleared", a_rdata, 32'd0);

        // Random traffic; requests are held until granted
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i] && ($urandom_range(0, 3) != 0)) begin
                    p_v[i]  = 1'b1;
                    p_we[i] = ($urandom_range(0, 1) == 1);
                    p_ad[i] = 4'($urandom_range(0, 15));
                    p_wd[i] = $urandom;
                end
            end
            r_rand = ($urandom_range(0, 49) == 0);
            step(r_rand, p_v[0], p_we[0], p_ad[0], p_wd[0], p_v[1], p_we[1], p_ad[1], p_wd[1]);
            for (int i = 0; i < 2; i++) begin
                if (m_g[i]) p_v[i] = 1'b0;
            end
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
